// File: rtl/uart_rx_cmd_decoder.sv
// uart_rx_cmd_decoder
//
// Parses command frames arriving from the UART receiver, one byte per
// RX_D_VLD pulse, and turns them into register-file and ALU strobes.
//
//   0xAA addr data       register write  -> WrEn, Address=addr, WrData=data
//   0xBB addr            register read   -> RdEn, Address=addr
//   0xCC opA opB fun     ALU with operands: opA -> reg 0, opB -> reg 1, ALU_EN
//   0xDD fun             ALU without operands -> ALU_EN, ALU_FUN=fun
//
// Ports:
//   CLK          system clock
//   RST          synchronous, active-high reset
//   RX_P_DATA    received byte, qualified by RX_D_VLD
//   RX_D_VLD     one-cycle pulse per received byte
//   WrEn, RdEn   one-cycle register-file strobes
//   Address      register-file address, held between strobes
//   WrData       register-file write data, held between strobes
//   ALU_EN       one-cycle ALU start strobe
//   ALU_FUN      ALU function code, held between strobes
//   CLK_GATE_EN  ALU clock-gate enable, high from 0xCC/0xDD through ALU_EN
//   FRAME_ERR    one-cycle pulse on an unknown command byte or a timeout
//
// All outputs are registered; results appear the cycle after the byte.

module uart_rx_cmd_decoder #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALU_FUN_WIDTH  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [ADDR_WIDTH-1:0]    Address,
  output logic [DATA_WIDTH-1:0]    WrData,
  output logic                     ALU_EN,
  output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
  output logic                     CLK_GATE_EN,
  output logic                     FRAME_ERR
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The abort is registered, so it is decided one count early: with a byte
  // in cycle 0, silence through cycle TIMEOUT_CYCLES-1 gives FRAME_ERR in
  // cycle TIMEOUT_CYCLES, while a byte in cycle TIMEOUT_CYCLES-1 still wins.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_OPS = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_FN  = DATA_WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    OPA,
    OPB,
    ALU_FN
  } state_t;

  state_t                   state, state_d;
  logic [CNT_W-1:0]         cnt, cnt_d;
  logic [ADDR_WIDTH-1:0]    addr_lat, addr_lat_d;

  logic                     wr_en_d, rd_en_d, alu_en_d, gate_d, ferr_d;
  logic [ADDR_WIDTH-1:0]    addr_d;
  logic [DATA_WIDTH-1:0]    wdata_d;
  logic [ALU_FUN_WIDTH-1:0] fun_d;

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    addr_lat_d = addr_lat;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    alu_en_d   = 1'b0;
    ferr_d     = 1'b0;
    addr_d     = Address;
    wdata_d    = WrData;
    fun_d      = ALU_FUN;
    // The gate drops the cycle after ALU_EN unless a new ALU command
    // arrives in that same cycle and re-arms it below.
    gate_d     = ALU_EN ? 1'b0 : CLK_GATE_EN;

    if (state == IDLE) begin
      cnt_d = '0;
      if (RX_D_VLD) begin
        case (RX_P_DATA)
          CMD_WR:  state_d = WR_ADDR;
          CMD_RD:  state_d = RD_ADDR;
          CMD_OPS: begin
            state_d = OPA;
            gate_d  = 1'b1;
          end
          CMD_FN:  begin
            state_d = ALU_FN;
            gate_d  = 1'b1;
          end
          default: ferr_d = 1'b1;
        endcase
      end
    end else if (RX_D_VLD) begin
      // Inside a frame every byte is payload, including command values.
      cnt_d = '0;
      case (state)
        WR_ADDR: begin
          addr_lat_d = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d    = WR_DATA;
        end
        WR_DATA: begin
          wr_en_d = 1'b1;
          addr_d  = addr_lat;
          wdata_d = RX_P_DATA;
          state_d = IDLE;
        end
        RD_ADDR: begin
          rd_en_d = 1'b1;
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = IDLE;
        end
        OPA: begin
          wr_en_d = 1'b1;
          addr_d  = ADDR_WIDTH'(0);
          wdata_d = RX_P_DATA;
          state_d = OPB;
        end
        OPB: begin
          wr_en_d = 1'b1;
          addr_d  = ADDR_WIDTH'(1);
          wdata_d = RX_P_DATA;
          state_d = ALU_FN;
        end
        ALU_FN: begin
          alu_en_d = 1'b1;
          fun_d    = RX_P_DATA[ALU_FUN_WIDTH-1:0];
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (cnt == CNT_LAST) begin
      ferr_d  = 1'b1;
      gate_d  = 1'b0;
      cnt_d   = '0;
      state_d = IDLE;
    end else begin
      cnt_d = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      WrEn        <= 1'b0;
      RdEn        <= 1'b0;
      Address     <= '0;
      WrData      <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      FRAME_ERR   <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      WrEn        <= wr_en_d;
      RdEn        <= rd_en_d;
      Address     <= addr_d;
      WrData      <= wdata_d;
      ALU_EN      <= alu_en_d;
      ALU_FUN     <= fun_d;
      CLK_GATE_EN <= gate_d;
      FRAME_ERR   <= ferr_d;
    end
  end

  // Latched write address is only consumed after WR_ADDR has loaded it.
  always_ff @(posedge CLK) begin
    addr_lat <= addr_lat_d;
  end

endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
module tb_uart_rx_cmd_decoder;

  localparam int T = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] RX_P_DATA = 8'h00;
  logic       RX_D_VLD = 1'b0;
  logic       WrEn, RdEn, ALU_EN, CLK_GATE_EN, FRAME_ERR;
  logic [3:0] Address, ALU_FUN;
  logic [7:0] WrData;

  int checks   = 0;
  int failures = 0;

  uart_rx_cmd_decoder #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_FUN_WIDTH(4), .TIMEOUT_CYCLES(T)
  ) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN),
    .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  // Reference model: frame bytes collected by position within the frame,
  // plus a count of silent cycles since the last byte of an open frame.
  bit         m_wr, m_rd, m_alu, m_ferr, m_gate;
  logic [3:0] m_addr, m_fun, m_lat;
  logic [7:0] m_wd, m_cmd;
  int         m_len, m_idle;

  task automatic model_step(input bit rst, input bit vld, input logic [7:0] b);
    bit prev_alu;
    if (rst) begin
      m_wr = 0; m_rd = 0; m_alu = 0; m_ferr = 0; m_gate = 0;
      m_addr = 0; m_fun = 0; m_wd = 0; m_len = 0; m_idle = 0;
    end else begin
      prev_alu = m_alu;
      m_wr = 0; m_rd = 0; m_alu = 0; m_ferr = 0;
      if (prev_alu) m_gate = 0;
      if (vld) begin
        m_idle = 0;
        if (m_len == 0) begin
          if (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD) begin
            m_cmd = b;
            m_len = 1;
            if (b == 8'hCC || b == 8'hDD) m_gate = 1;
          end else begin
            m_ferr = 1;
          end
        end else begin
          case (m_cmd)
            8'hAA: if (m_len == 1) begin m_lat = b[3:0]; m_len = 2; end
                   else begin m_wr = 1; m_addr = m_lat; m_wd = b; m_len = 0; end
            8'hBB: begin m_rd = 1; m_addr = b[3:0]; m_len = 0; end
            8'hCC: if (m_len == 1) begin m_wr = 1; m_addr = 0; m_wd = b; m_len = 2; end
                   else if (m_len == 2) begin m_wr = 1; m_addr = 1; m_wd = b; m_len = 3; end
                   else begin m_alu = 1; m_fun = b[3:0]; m_len = 0; end
            default: begin m_alu = 1; m_fun = b[3:0]; m_len = 0; end
          endcase
        end
      end else if (m_len != 0) begin
        m_idle++;
        if (m_idle == T - 1) begin
          m_ferr = 1; m_gate = 0; m_len = 0; m_idle = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, let the edge pass, compare against the model.
  task automatic step(input bit rst, input bit vld, input logic [7:0] b);
    RST = rst; RX_D_VLD = vld; RX_P_DATA = b;
    @(posedge CLK); #1;
    model_step(rst, vld, b);
    chk("WrEn",        8'(WrEn),        8'(m_wr));
    chk("RdEn",        8'(RdEn),        8'(m_rd));
    chk("ALU_EN",      8'(ALU_EN),      8'(m_alu));
    chk("FRAME_ERR",   8'(FRAME_ERR),   8'(m_ferr));
    chk("CLK_GATE_EN", 8'(CLK_GATE_EN), 8'(m_gate));
    chk("Address",     8'(Address),     8'(m_addr));
    chk("WrData",      WrData,          m_wd);
    chk("ALU_FUN",     8'(ALU_FUN),     8'(m_fun));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00);
  endtask

  initial begin
    int err_at;
    bit wr_seen;

    // Reset with RX_D_VLD toggling
    step(1, 1, 8'hAA);
    step(1, 0, 8'h00);
    chk("rst_outputs", {WrEn, RdEn, ALU_EN, FRAME_ERR, CLK_GATE_EN, 3'b000}, 8'h00);
    chk("rst_address", 8'(Address), 8'h00);
    step(0, 1, 8'hBB);
    step(0, 1, 8'h03);
    chk("rd_pulse", 8'(RdEn), 8'h01);
    chk("rd_addr", 8'(Address), 8'h03);
    idle(2);

    // Back-to-back write frame
    step(0, 1, 8'hAA);
    step(0, 1, 8'h05);
    chk("wr_early", 8'(WrEn), 8'h00);
    step(0, 1, 8'h5A);
    chk("wr_pulse", 8'(WrEn), 8'h01);
    chk("wr_addr", 8'(Address), 8'h05);
    chk("wr_data", WrData, 8'h5A);
    step(0, 0, 8'h00);
    chk("wr_single", 8'(WrEn), 8'h00);
    idle(2);

    // ALU frame with 10-cycle spacing
    step(0, 1, 8'hCC); chk("gate_on", 8'(CLK_GATE_EN), 8'h01); idle(9);
    step(0, 1, 8'h12); chk("opa_addr", 8'(Address), 8'h00); chk("opa_data", WrData, 8'h12); idle(9);
    step(0, 1, 8'h34); chk("opb_addr", 8'(Address), 8'h01); chk("opb_data", WrData, 8'h34); idle(9);
    step(0, 1, 8'h07);
    chk("alu_en", 8'(ALU_EN), 8'h01);
    chk("alu_fun", 8'(ALU_FUN), 8'h07);
    chk("gate_thru_alu", 8'(CLK_GATE_EN), 8'h01);
    step(0, 0, 8'h00);
    chk("gate_off", 8'(CLK_GATE_EN), 8'h00);
    idle(2);

    // Unknown command then short ALU frame with upper bits set
    step(0, 1, 8'h55); chk("unk_err", 8'(FRAME_ERR), 8'h01);
    step(0, 0, 8'h00); chk("unk_err_single", 8'(FRAME_ERR), 8'h00);
    step(0, 1, 8'hDD);
    step(0, 1, 8'h1F);
    chk("dd_alu_en", 8'(ALU_EN), 8'h01);
    chk("dd_alu_fun", 8'(ALU_FUN), 8'h0F);
    idle(2);

    // Timeout: silence after 0xAA,0x02 (0x02 is cycle 0)
    step(0, 1, 8'hAA);
    step(0, 1, 8'h02);
    err_at = 0; wr_seen = 0;
    for (int i = 1; i <= 20; i++) begin
      step(0, 0, 8'h00);
      if (FRAME_ERR === 1'b1 && err_at == 0) err_at = i + 1;
      if (WrEn === 1'b1) wr_seen = 1;
    end
    chk("timeout_cycle", 8'(err_at), 8'd16);
    chk("timeout_no_wr", 8'(wr_seen), 8'h00);
    step(0, 1, 8'hBB);
    step(0, 1, 8'h09);
    chk("after_timeout_rd", 8'(RdEn), 8'h01);

    // Data byte at cycle 15 beats the timeout
    step(0, 1, 8'hAA);
    step(0, 1, 8'h02);
    idle(14);
    step(0, 1, 8'h77);
    chk("late_wr", 8'(WrEn), 8'h01);
    chk("late_no_err", 8'(FRAME_ERR), 8'h00);
    chk("late_data", WrData, 8'h77);
    idle(20);

    // Reset in the middle of an ALU frame
    step(0, 1, 8'hCC);
    step(0, 1, 8'h11);
    step(1, 0, 8'h00);
    chk("midrst_gate", 8'(CLK_GATE_EN), 8'h00);
    step(0, 1, 8'h22);
    chk("midrst_no_wr", 8'(WrEn), 8'h00);
    chk("midrst_err", 8'(FRAME_ERR), 8'h01);
    idle(2);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      int r, sel;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        step(1, $urandom_range(0, 1), 8'($urandom));
      end else if (r < 7) begin
        idle($urandom_range(12, 18));
      end else begin
        sel = $urandom_range(0, 5);
        case (sel)
          0: b = 8'hAA;
          1: b = 8'hBB;
          2: b = 8'hCC;
          3: b = 8'hDD;
          default: b = 8'($urandom);
        endcase
        step(0, $urandom_range(0, 1), b);
      end
    end

    RX_D_VLD = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_cmd_decoder.md
Name: uart_rx_cmd_decoder

Overview:
Frame decoder that sits directly downstream of the UART receiver. It consumes the receiver's parallel byte stream (one valid pulse per byte) and parses multi-byte command frames: register write, register read, ALU operation with operands, and ALU operation without operands. It issues single-cycle register-file and ALU strobes and a clock-gate enable for the ALU domain. An inter-byte timeout recovers from truncated frames.

Parameters:
DATA_WIDTH, 8, width of received byte and register-file write data
ADDR_WIDTH, 4, register-file address width; taken from the byte LSBs
ALU_FUN_WIDTH, 4, ALU function code width; taken from the byte LSBs
TIMEOUT_CYCLES, 4096, maximum idle CLK cycles between bytes of one frame (>=2)

Ports:
CLK  in  1  system clock; single clock domain
RST  in  1  synchronous, active-high reset
RX_P_DATA  in  DATA_WIDTH  received byte from UART RX
RX_D_VLD  in  1  one-cycle pulse; RX_P_DATA valid this cycle
WrEn  out  1  register-file write strobe, 1-cycle pulse
RdEn  out  1  register-file read strobe, 1-cycle pulse
Address  out  ADDR_WIDTH  register-file address, held between strobes
WrData  out  DATA_WIDTH  register-file write data, held between strobes
ALU_EN  out  1  ALU start strobe, 1-cycle pulse
ALU_FUN  out  ALU_FUN_WIDTH  ALU function code, held between strobes
CLK_GATE_EN  out  1  ALU clock-gate enable, driven directly from a flop
FRAME_ERR  out  1  1-cycle pulse on unknown command byte or timeout

Behaviour:
- Clock is CLK; reset is synchronous, active-high RST. On RST=1 at a CLK edge: state=IDLE, timeout counter=0, every output=0. RST overrides any in-flight frame; no strobe is issued for it.
- All outputs are registered. A byte is accepted in the cycle RX_D_VLD=1. Resulting strobes/data appear in the next cycle. Back-to-back RX_D_VLD on consecutive cycles is legal; every pulse is accepted.
- States and transitions. Each transition happens on an accepted byte B:
  - IDLE: B=0xAA->WR_ADDR; B=0xBB->RD_ADDR; B=0xCC->OPA; B=0xDD->ALU_FN. Any other B: FRAME_ERR pulse, stay IDLE.
  - WR_ADDR: latch addr=B[ADDR_WIDTH-1:0] internally (Address output unchanged) ->WR_DATA.
  - WR_DATA: WrEn=1, Address=latched addr, WrData=B ->IDLE.
  - RD_ADDR: RdEn=1, Address=B[ADDR_WIDTH-1:0] ->IDLE.
  - OPA: WrEn=1, Address=0, WrData=B ->OPB.
  - OPB: WrEn=1, Address=1, WrData=B ->ALU_FN.
  - ALU_FN: ALU_EN=1, ALU_FUN=B[ALU_FUN_WIDTH-1:0] ->IDLE.
- Command bytes are decoded only in IDLE. 0xAA/0xBB/0xCC/0xDD in any other state are treated as payload.
- Strobes last exactly one cycle. Address/WrData/ALU_FUN hold their last value until overwritten.
- CLK_GATE_EN:
  - Set on acceptance of 0xCC or 0xDD in IDLE, so it is 1 in the same cycle the state becomes OPA/ALU_FN.
  - Stays 1 through the ALU_EN cycle.
  - Clears so it is 0 in the cycle after ALU_EN=1.
  - Also clears on timeout abort or RST.
- Timeout:
  - The counter runs only in non-IDLE states and is zeroed on every accepted byte and on entry to IDLE.
  - If the counter reaches TIMEOUT_CYCLES-1 with no byte: FRAME_ERR pulse next cycle, state->IDLE, no strobe, CLK_GATE_EN->0.
  - If RX_D_VLD=1 in the same cycle the timeout would fire, the byte wins and no error is raised.
- FRAME_ERR and a strobe are never asserted in the same cycle.
- Width rule: upper byte bits beyond ADDR_WIDTH/ALU_FUN_WIDTH are ignored, with no error.

Test Plan:
- Reset: hold RST=1 for 2 cycles with RX_D_VLD toggling -> all outputs 0, and the next 0xBB,0x03 frame decodes normally (RdEn pulse, Address=3).
- Write frame 0xAA,0x05,0x5A on consecutive cycles -> exactly one WrEn pulse, 1 cycle after the 0x5A byte, with Address=5, WrData=0x5A; RdEn/ALU_EN stay 0.
- ALU frame 0xCC,0x12,0x34,0x07 spaced 10 cycles apart:
  - WrEn pulse at Address=0, WrData=0x12.
  - WrEn pulse at Address=1, WrData=0x34.
  - ALU_EN pulse with ALU_FUN=7.
  - CLK_GATE_EN high from the cycle after 0xCC through the ALU_EN cycle, low the cycle after.
- Unknown command 0x55 in IDLE -> FRAME_ERR single pulse; a following 0xDD,0x1F frame -> ALU_EN with ALU_FUN=0xF.
- Timeout, with TIMEOUT_CYCLES=16:
  - Send 0xAA,0x02, then silence -> FRAME_ERR pulse 16 cycles after the 0x02 byte, no WrEn, state IDLE.
  - Repeat with the data byte arriving exactly at cycle 15 -> WrEn issued, no FRAME_ERR.
- Reset mid-frame: 0xCC,0x11, then RST for 1 cycle, then 0x22 -> no WrEn for 0x22; FRAME_ERR (0x22 is unknown in IDLE); CLK_GATE_EN=0 after reset.
